ysyx_23060184_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_23060184_ifu_prefetch
// PURPOSE
//  Instruction-fetch unit with an AXI4-lite read master and a DEPTH-entry prefetch queue.
//  Fetches sequentially from a redirectable PC, one read in flight at a time, and queues {pc, inst, err} for decode.
//  Sits between the fetch-stage PC logic and the bus arbiter, replacing the single-shot fetch handshake.
//  Adds back-to-back fetching, flush/redirect with response draining, and rresp error capture.
// PARAMETERS
//  ADDR_W    32            address / PC width
//  DATA_W    32            instruction width; PC increments by DATA_W/8
//  DEPTH     4             prefetch queue entries; power of 2, >= 2
//  ACERR_W   2             rresp width
//  RESET_PC  32'h8000_0000 fetch PC after reset
// PORTS
//  clk         in   1        clock
//  resetn      in   1        synchronous active-low reset
//  flush_i     in   1        redirect: discard queue and in-flight data
//  flush_pc_i  in   ADDR_W   new fetch PC when flush_i=1
//  grant_i     in   1        arbiter grant for this master
//  req_o       out  1        bus request to arbiter
//  araddr_o    out  ADDR_W   read address
//  arvalid_o   out  1        read address valid
//  arready_i   in   1        read address ready
//  rdata_i     in   DATA_W   read data
//  rresp_i     in   ACERR_W  read response; 0 = OKAY
//  rvalid_i    in   1        read data valid
//  rready_o    out  1        read data ready
//  inst_valid_o out 1        queue head valid
//  inst_ready_i in  1        decode accepts head
//  inst_o      out  DATA_W   head instruction
//  pc_o        out  ADDR_W   head PC
//  err_o       out  1        head fetch got non-OKAY rresp
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state=IDLE, fetch_pc=RESET_PC, queue empty, halted=0.
//   All outputs 0 except araddr_o=RESET_PC.
//  FSM states:
//   IDLE: if !flush_i && !halted && (count+inflight) < DEPTH -> req_o=1; on grant_i -> AR.
//   AR: arvalid_o=1, araddr_o=fetch_pc, req_o=1. Hold arvalid_o and araddr_o stable until arready_i.
//    On handshake -> R, or -> DRAIN if flush seen in AR or at the handshake edge.
//   R: rready_o=1, req_o=1. On rvalid_i: push {fetch_pc, rdata_i, rresp_i!=0}; fetch_pc += DATA_W/8.
//    If rresp_i!=0, set halted=1. Then -> IDLE.
//   DRAIN: rready_o=1, req_o=1. On rvalid_i: discard data -> IDLE.
//  req_o stays high from AR entry through R/DRAIN completion. Arbiter holds grant_i meanwhile.
//  flush_i:
//   queue cleared next cycle; fetch_pc<=flush_pc_i; halted<=0.
//   In AR: arvalid is not dropped; a flag routes the fetch to DRAIN.
//   In R with rvalid_i the same cycle: response discarded, no push.
//  Queue: push when R && rvalid_i && !flush_i. Pop when inst_valid_o && inst_ready_i && !flush_i.
//   Push and pop in the same cycle keep count unchanged. Pointers wrap mod DEPTH.
//   inst_valid_o = count!=0. inst_o, pc_o and err_o come from head storage: registered, no bypass.
//  Space check counts the in-flight fetch, so a push never finds the queue full.
//  Latency from IDLE with an empty queue, grant_i=1, zero-wait bus: arvalid_o at cycle 1,
//   rready_o at cycle 2, inst_valid_o at cycle 3.
//  Sustained rate: one instruction per 3 cycles with a zero-wait bus.
//  halted: no new fetch until flush_i. The error entry still drains through the queue normally.
// STRUCTURE
//  Shared defines header: ADDR/DATA/ACERR widths, RESP_OKAY, FSM encodings IDLE/AR/R/DRAIN.
//  Sub-module ysyx_23060184_sync_fifo (WIDTH, DEPTH):
//   push/pop/flush, full, empty, count, head data.
//  Top level holds the FSM, fetch_pc, halted and the drain flag.
// TESTING
//  1. Reset, grant=1, zero-wait memory returning araddr as data -> heads 8000_0000, 8000_0004, 8000_0008.
//     pc_o == inst_o and err_o=0 on every head.
//  2. inst_ready_i=0 with DEPTH=4 -> exactly 4 fetches, then req_o=0. One pop -> exactly one new fetch.
//  3. flush_i (pc 8000_1000) in R with rvalid_i the same cycle -> no push, queue empty next cycle.
//     Next araddr_o = 8000_1000.
//  4. flush_i in AR with arready_i low for 3 cycles -> arvalid_o held and stable.
//     Response drained, then fetch at flush_pc.
//  5. rresp_i=2 at 8000_0008 -> head err_o=1, req_o stays 0.
//     flush_i to 8000_0000 -> fetching resumes, err_o=0.
//  6. Reset asserted in R -> next cycle all outputs are reset values; later fetch starts at 8000_0000.
//     Random rvalid_i/arready_i delays plus random inst_ready_i match a reference model:
//     PC sequence exact, no loss or duplication.

Source files
------------

// File: rtl/ysyx_23060184_ifu_prefetch_pkg.sv
// Shared widths, response codes and FSM encodings for the prefetching fetch unit.
package ysyx_23060184_ifu_prefetch_pkg;
  localparam int unsigned IFU_ADDR_W  = 32;
  localparam int unsigned IFU_DATA_W  = 32;
  localparam int unsigned IFU_ACERR_W = 2;
  localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 32'h8000_0000;

  localparam logic [IFU_ACERR_W-1:0] RESP_OKAY = '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_AR    = 2'd1;
  localparam logic [1:0] ST_R     = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
endpackage

// File: rtl/ysyx_23060184_ifu_prefetch_if.sv
// Arbiter request/grant plus AXI4-lite read channels between the fetch unit and the bus.
interface ysyx_23060184_ifu_prefetch_if
  import ysyx_23060184_ifu_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = IFU_ADDR_W,
  parameter int unsigned DATA_W  = IFU_DATA_W,
  parameter int unsigned ACERR_W = IFU_ACERR_W
) ();
  logic               req;
  logic               grant;
  logic [ADDR_W-1:0]  araddr;
  logic               arvalid;
  logic               arready;
  logic [DATA_W-1:0]  rdata;
  logic [ACERR_W-1:0] rresp;
  logic               rvalid;
  logic               rready;

  modport master (
    output req, araddr, arvalid, rready,
    input  grant, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  req, araddr, arvalid, rready,
    output grant, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060184_sync_fifo.sv
// Synchronous FIFO with registered head output and single-cycle flush.
module ysyx_23060184_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ysyx_23060184_ifu_prefetch.sv
// Sequential instruction fetch with one AXI4-lite read in flight, redirect/drain and a prefetch queue.
module ysyx_23060184_ifu_prefetch
  import ysyx_23060184_ifu_prefetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = IFU_ADDR_W,
  parameter int unsigned         DATA_W   = IFU_DATA_W,
  parameter int unsigned         DEPTH    = 4,
  parameter int unsigned         ACERR_W  = IFU_ACERR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = IFU_RESET_PC
) (
  input  logic                      clk,
  input  logic                      resetn,
  ysyx_23060184_ifu_prefetch_if.master bus,
  input  logic                      flush_i,
  input  logic [ADDR_W-1:0]         flush_pc_i,
  output logic                      inst_valid_o,
  input  logic                      inst_ready_i,
  output logic [DATA_W-1:0]         inst_o,
  output logic [ADDR_W-1:0]         pc_o,
  output logic                      err_o
);
  localparam int unsigned       ENTRY_W = ADDR_W + DATA_W + 1;
  localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  ar_addr;
  logic               halted;
  logic               drain;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic               rsp_err;
  logic               push;
  logic               pop;
  logic               can_fetch;

  // Fetches are serialized and only issued from IDLE, so nothing is in flight here.
  assign can_fetch = resetn && !flush_i && !halted && (count < CNT_W'(DEPTH));
  assign rsp_err   = (bus.rresp != RESP_OKAY);
  assign push      = (state == ST_R) && bus.rvalid && !flush_i && !full;
  assign pop       = inst_valid_o && inst_ready_i && !flush_i;

  assign bus.req     = (state == ST_IDLE) ? can_fetch : 1'b1;
  assign bus.arvalid = (state == ST_AR);
  assign bus.araddr  = (state == ST_IDLE) ? fetch_pc : ar_addr;
  assign bus.rready  = (state == ST_R) || (state == ST_DRAIN);

  assign inst_valid_o = !empty;
  assign {pc_o, inst_o, err_o} = head;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      ar_addr  <= RESET_PC;
      halted   <= 1'b0;
      drain    <= 1'b0;
    end else begin
      if (flush_i) begin
        fetch_pc <= flush_pc_i;
        halted   <= 1'b0;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_err) halted <= 1'b1;
      end

      case (state)
        ST_IDLE: if (can_fetch && bus.grant) begin
          state   <= ST_AR;
          ar_addr <= fetch_pc;
          drain   <= 1'b0;
        end
        // ar_addr is frozen so a redirect cannot disturb the pending address.
        ST_AR: begin
          if (flush_i) drain <= 1'b1;
          if (bus.arready) state <= (drain || flush_i) ? ST_DRAIN : ST_R;
        end
        // A redirect before the data arrives turns the rest of the read into a drain.
        ST_R: begin
          if (bus.rvalid)   state <= ST_IDLE;
          else if (flush_i) state <= ST_DRAIN;
        end
        ST_DRAIN: if (bus.rvalid) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  ysyx_23060184_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (flush_i),
    .din    ({fetch_pc, bus.rdata, rsp_err}),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .head   (head)
  );
endmodule

// File: tb/tb_ysyx_23060184_ifu_prefetch.sv
// Bench for the prefetching fetch unit: directed scenarios plus randomized bus/decode timing vs a PC-stream model.
module tb_ysyx_23060184_ifu_prefetch;
  import ysyx_23060184_ifu_prefetch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        err_o;

  ysyx_23060184_ifu_prefetch_if bus ();

  ysyx_23060184_ifu_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus.master),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs, consumed at the falling edge
  bit          rst_req = 1'b1;
  bit          rand_mode = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          rdy_fix = 1'b0;
  bit          flush_now = 1'b0;
  logic [31:0] flush_now_pc = '0;
  bit          flush_on_ar = 1'b0;
  bit          flush_on_r = 1'b0;
  logic [31:0] knob_pc = '0;
  int          ar_hold = 0;
  int          r_maxdly = 0;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] xor_key = '0;

  // memory slave state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          dly = 0;

  // reference model and observations
  logic [31:0] exp_pc = RST_PC;
  int          n_pop = 0;
  int          n_fetch = 0;
  logic [31:0] fetch_addr [$];
  bit          p_arwait = 1'b0;
  logic [31:0] p_araddr = '0;
  logic        s_req, s_arvalid, s_rready, s_valid, s_err;
  logic [31:0] s_araddr, s_inst, s_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ xor_key;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit ar_hs;
    bit r_hs;
    @(negedge clk);
    resetn = !rst_req;
    bus.rvalid  = pend && (dly == 0) && resetn;
    bus.rdata   = pend ? mem_data(pend_addr) : '0;
    bus.rresp   = (pend && pend_addr == err_addr) ? 2'd2 : 2'd0;
    bus.arready = 1'b0;
    if (bus.arvalid && !pend) begin
      if (ar_hold > 0) ar_hold--;
      else bus.arready = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
    flush_i    = flush_now;
    flush_pc_i = flush_now_pc;
    flush_now  = 1'b0;
    if (flush_on_r && bus.rvalid && bus.rready) begin
      flush_i = 1'b1; flush_pc_i = knob_pc; flush_on_r = 1'b0;
    end
    if (flush_on_ar && bus.arvalid) begin
      flush_i = 1'b1; flush_pc_i = knob_pc; flush_on_ar = 1'b0;
    end
    if (rand_mode && $urandom_range(0, 59) == 0) begin
      flush_i = 1'b1; flush_pc_i = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    end
    inst_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    bus.grant = (bus.arvalid || bus.rready) ? 1'b1 :
                (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    s_req = bus.req; s_arvalid = bus.arvalid; s_rready = bus.rready; s_araddr = bus.araddr;
    s_valid = inst_valid_o; s_inst = inst_o; s_pc = pc_o; s_err = err_o;
    if (resetn) begin
      if (p_arwait) begin
        check_eq("ar_held", bus.arvalid, 1);
        check_eq("ar_stable", bus.araddr, p_araddr);
      end
      if (inst_valid_o && inst_ready_i && !flush_i) begin
        check_eq("pc", pc_o, exp_pc);
        check_eq("inst", inst_o, mem_data(exp_pc));
        check_eq("err", err_o, exp_pc == err_addr);
        exp_pc += 4;
        n_pop++;
      end
      if (flush_i) exp_pc = flush_pc_i;
    end else begin
      exp_pc = RST_PC;
    end
    ar_hs    = resetn && bus.arvalid && bus.arready;
    r_hs     = resetn && bus.rvalid && bus.rready;
    p_arwait = resetn && bus.arvalid && !bus.arready;
    p_araddr = bus.araddr;
    @(posedge clk);
    if (!resetn) begin
      pend = 1'b0;
    end else begin
      if (r_hs) pend = 1'b0;
      else if (pend && dly > 0) dly--;
      if (ar_hs) begin
        pend = 1'b1; pend_addr = p_araddr; dly = $urandom_range(0, r_maxdly);
        n_fetch++; fetch_addr.push_back(p_araddr);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst_req = 1'b1; rand_mode = 1'b0; rdy_rand = 1'b0; rdy_fix = 1'b0;
    flush_on_ar = 1'b0; flush_on_r = 1'b0; ar_hold = 0; r_maxdly = 0;
    tick();
    tick();
    check_eq({tag, "_rst_req"}, s_req, 0);
    check_eq({tag, "_rst_arvalid"}, s_arvalid, 0);
    check_eq({tag, "_rst_rready"}, s_rready, 0);
    check_eq({tag, "_rst_valid"}, s_valid, 0);
    check_eq({tag, "_rst_araddr"}, s_araddr, RST_PC);
    check_eq({tag, "_rst_head"}, {s_inst, s_pc, s_err}, 0);
    rst_req = 1'b0;
    n_pop = 0; n_fetch = 0; fetch_addr.delete();
  endtask

  initial begin
    int a, r, v, arc, k;
    bus.grant = 1'b1; bus.arready = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 1'b0;

    // 1: latency and first heads with data == address
    do_reset("t1");
    rdy_fix = 1'b1; xor_key = '0; err_addr = 32'h1;
    a = -1; r = -1; v = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_arvalid && a < 0) a = i;
      if (s_rready && r < 0) r = i;
      if (s_valid && v < 0) v = i;
    end
    check_eq("t1_arvalid_cyc", a, 1);
    check_eq("t1_rready_cyc", r, 2);
    check_eq("t1_valid_cyc", v, 3);
    check_eq("t1_pops", n_pop, 3);
    check_eq("t1_fetch2", fetch_addr[2], 32'h8000_0008);

    // 2: queue fills to DEPTH, one pop frees exactly one fetch
    do_reset("t2");
    repeat (30) tick();
    check_eq("t2_fetches", n_fetch, DEPTH);
    check_eq("t2_req_idle", s_req, 0);
    check_eq("t2_valid", s_valid, 1);
    rdy_fix = 1'b1; tick(); rdy_fix = 1'b0;
    repeat (20) tick();
    check_eq("t2_one_pop", n_pop, 1);
    check_eq("t2_refetch", n_fetch, DEPTH + 1);
    check_eq("t2_req_idle2", s_req, 0);

    // 3: flush coincident with rvalid discards the response
    do_reset("t3");
    k = 0;
    while (!s_valid && k < 20) begin tick(); k++; end
    check_eq("t3_first_push", s_valid, 1);
    knob_pc = 32'h8000_1000; flush_on_r = 1'b1;
    k = 0;
    while (flush_on_r && k < 20) begin tick(); k++; end
    check_eq("t3_flush_hit", flush_on_r, 0);
    tick();
    check_eq("t3_empty", s_valid, 0);
    k = 0;
    while (!s_arvalid && k < 20) begin tick(); k++; end
    check_eq("t3_araddr", s_araddr, 32'h8000_1000);
    rdy_fix = 1'b1;
    repeat (10) tick();
    check_eq("t3_resumed", n_pop > 0, 1);

    // 4: flush while AR is stalled; address held, response drained, refetch at flush_pc
    do_reset("t4");
    rdy_fix = 1'b1; ar_hold = 3; knob_pc = 32'h8000_2000; flush_on_ar = 1'b1;
    arc = 0; k = 0;
    while (n_fetch < 1 && k < 30) begin tick(); if (s_arvalid) arc++; k++; end
    check_eq("t4_ar_cycles", arc, 4);
    k = 0;
    while (n_pop < 1 && k < 30) begin tick(); k++; end
    check_eq("t4_popped", n_pop, 1);
    check_eq("t4_fetch0", fetch_addr[0], 32'h8000_0000);
    check_eq("t4_fetch1", fetch_addr[1], 32'h8000_2000);

    // 5: error response halts fetching until a redirect
    do_reset("t5");
    err_addr = 32'h8000_0008;
    repeat (20) tick();
    check_eq("t5_fetches", n_fetch, 3);
    check_eq("t5_req_halt", s_req, 0);
    rdy_fix = 1'b1;
    repeat (8) tick();
    check_eq("t5_pops", n_pop, 3);
    check_eq("t5_req_still", s_req, 0);
    check_eq("t5_drained", s_valid, 0);
    flush_now = 1'b1; flush_now_pc = RST_PC;
    tick();
    err_addr = 32'h1;
    repeat (12) tick();
    check_eq("t5_resumed", n_pop > 3, 1);
    check_eq("t5_refetch", fetch_addr[3], RST_PC);

    // 6: reset in the middle of a read
    do_reset("t6a");
    rdy_fix = 1'b1;
    k = 0;
    while (!s_rready && k < 20) begin tick(); k++; end
    check_eq("t6_in_r", s_rready, 1);
    do_reset("t6");
    k = 0;
    while (n_fetch < 1 && k < 20) begin tick(); k++; end
    check_eq("t6_fetch_pc", fetch_addr[0], RST_PC);

    // randomized timing against the PC-stream model
    do_reset("rnd");
    rand_mode = 1'b1; rdy_rand = 1'b1; r_maxdly = 3; xor_key = $urandom;
    repeat (3000) tick();
    check_eq("rnd_progress", n_pop > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
